// File: rtl/rv151_pkg.sv
// Shared constants for the rv151 core: datapath widths, register indexing
// and the writeback-select encodings used by the control unit and wb mux.
package rv151_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;
   localparam int NREGS     = 32;

   localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

   typedef enum logic [1:0] {
      WB_PC4 = 2'd0,
      WB_ALU = 2'd1,
      WB_MEM = 2'd2
   } wb_sel_e;

endpackage

// File: rtl/reg_file_wb_reg_array.sv
// Raw register storage: one synchronous write port with synchronous clear and
// two asynchronous read ports. No x0 handling or bypass lives here.
module reg_array
   import rv151_pkg::*;
#(
   parameter int XLEN  = rv151_pkg::XLEN,
   parameter int NREGS = rv151_pkg::NREGS
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 we,
   input  logic [REG_IDX_W-1:0] waddr,
   input  logic [XLEN-1:0]      wdata,
   input  logic [REG_IDX_W-1:0] raddr1,
   input  logic [REG_IDX_W-1:0] raddr2,
   output logic [XLEN-1:0]      rdata1,
   output logic [XLEN-1:0]      rdata2
);

   logic [XLEN-1:0] mem_q [NREGS];

   // Indices beyond NREGS are silently dropped on write and read back as zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we && (int'(waddr) < NREGS)) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata1 = (int'(raddr1) < NREGS) ? mem_q[raddr1] : '0;
   assign rdata2 = (int'(raddr2) < NREGS) ? mem_q[raddr2] : '0;

endmodule

// File: rtl/reg_file_wb.sv
// rv151 integer register file fed by the writeback mux: x0 masking,
// same-cycle write-to-read bypass, and a last-write / retired-write record.
module reg_file_wb
   import rv151_pkg::*;
#(
   parameter int XLEN  = rv151_pkg::XLEN,
   parameter int NREGS = rv151_pkg::NREGS,
   parameter int CNT_W = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_wb_en,
   input  logic [REG_IDX_W-1:0] io_wb_rd,
   input  logic [XLEN-1:0]      io_wb_data,
   input  logic [REG_IDX_W-1:0] io_rs1,
   input  logic [REG_IDX_W-1:0] io_rs2,
   output logic [XLEN-1:0]      io_rd1,
   output logic [XLEN-1:0]      io_rd2,
   output logic [REG_IDX_W-1:0] io_last_rd,
   output logic [XLEN-1:0]      io_last_data,
   output logic [CNT_W-1:0]     io_wr_count
);

   logic                 commit;
   logic [XLEN-1:0]      rawRd1;
   logic [XLEN-1:0]      rawRd2;
   logic [REG_IDX_W-1:0] lastRd_q, lastRd_d;
   logic [XLEN-1:0]      lastData_q, lastData_d;
   logic [CNT_W-1:0]     wrCount_q, wrCount_d;

   // Reset suppresses commit, which also switches the bypass off during reset.
   assign commit = io_wb_en && (io_wb_rd != X0_IDX) && !reset;

   reg_array #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_array (
      .clock  (clock),
      .reset  (reset),
      .we     (commit),
      .waddr  (io_wb_rd),
      .wdata  (io_wb_data),
      .raddr1 (io_rs1),
      .raddr2 (io_rs2),
      .rdata1 (rawRd1),
      .rdata2 (rawRd2)
   );

   always_comb begin
      io_rd1 = rawRd1;
      if (io_rs1 == X0_IDX) begin
         io_rd1 = '0;
      end else if (commit && (io_wb_rd == io_rs1)) begin
         io_rd1 = io_wb_data;
      end
   end

   always_comb begin
      io_rd2 = rawRd2;
      if (io_rs2 == X0_IDX) begin
         io_rd2 = '0;
      end else if (commit && (io_wb_rd == io_rs2)) begin
         io_rd2 = io_wb_data;
      end
   end

   // The counter wraps naturally at its width with no overflow indication.
   always_comb begin
      lastRd_d   = lastRd_q;
      lastData_d = lastData_q;
      wrCount_d  = wrCount_q;
      if (commit) begin
         lastRd_d   = io_wb_rd;
         lastData_d = io_wb_data;
         wrCount_d  = wrCount_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lastRd_q   <= '0;
         lastData_q <= '0;
         wrCount_q  <= '0;
      end else begin
         lastRd_q   <= lastRd_d;
         lastData_q <= lastData_d;
         wrCount_q  <= wrCount_d;
      end
   end

   assign io_last_rd   = lastRd_q;
   assign io_last_data = lastData_q;
   assign io_wr_count  = wrCount_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb built with a 4-bit counter so the wrap
// case is reachable; expectations are queued by the driver, checked by a monitor.
module tb_reg_file_wb;

   localparam int CW = 4;

   logic          clock;
   logic          reset;
   logic          io_wb_en;
   logic [4:0]    io_wb_rd;
   logic [31:0]   io_wb_data;
   logic [4:0]    io_rs1;
   logic [4:0]    io_rs2;
   logic [31:0]   io_rd1;
   logic [31:0]   io_rd2;
   logic [4:0]    io_last_rd;
   logic [31:0]   io_last_data;
   logic [CW-1:0] io_wr_count;

   typedef enum int {SEL_RD1, SEL_RD2, SEL_LASTRD, SEL_LASTDATA, SEL_COUNT} sel_e;

   typedef struct {
      string       name;
      sel_e        sel;
      logic [31:0] val;
   } exp_t;

   exp_t expQ[$];
   int   compared   = 0;
   int   mismatched = 0;

   reg_file_wb #(
      .XLEN  (32),
      .NREGS (32),
      .CNT_W (CW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .io_wb_en     (io_wb_en),
      .io_wb_rd     (io_wb_rd),
      .io_wb_data   (io_wb_data),
      .io_rs1       (io_rs1),
      .io_rs2       (io_rs2),
      .io_rd1       (io_rd1),
      .io_rd2       (io_rd2),
      .io_last_rd   (io_last_rd),
      .io_last_data (io_last_data),
      .io_wr_count  (io_wr_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs change on the falling edge so the next rising edge sees them settled.
   task automatic applyStimulus(input logic rst, input logic en, input logic [4:0] rd,
                                input logic [31:0] data, input logic [4:0] rs1,
                                input logic [4:0] rs2);
      @(negedge clock);
      reset      = rst;
      io_wb_en   = en;
      io_wb_rd   = rd;
      io_wb_data = data;
      io_rs1     = rs1;
      io_rs2     = rs2;
   endtask

   task automatic checkOutput(input string name, input sel_e sel, input logic [31:0] val);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.val  = val;
      expQ.push_back(e);
   endtask

   // Monitor: everything queued for a cycle is checked mid-low-phase.
   initial begin
      forever begin
         @(negedge clock);
         #2;
         while (expQ.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = expQ.pop_front();
            case (e.sel)
               SEL_RD1:      act = io_rd1;
               SEL_RD2:      act = io_rd2;
               SEL_LASTRD:   act = 32'(io_last_rd);
               SEL_LASTDATA: act = io_last_data;
               default:      act = 32'(io_wr_count);
            endcase
            compared++;
            if (act !== e.val) begin
               mismatched++;
               $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
            end
         end
      end
   end

   initial begin
      reset      = 1'b1;
      io_wb_en   = 1'b0;
      io_wb_rd   = '0;
      io_wb_data = '0;
      io_rs1     = '0;
      io_rs2     = '0;

      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

      // Post-reset sweep of every index on both ports
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
         checkOutput($sformatf("reset_rd1_x%0d", i), SEL_RD1, 32'h0);
         checkOutput($sformatf("reset_rd2_x%0d", 31 - i), SEL_RD2, 32'h0);
         if (i == 0) begin
            checkOutput("reset_count", SEL_COUNT, 32'h0);
            checkOutput("reset_last_rd", SEL_LASTRD, 32'h0);
            checkOutput("reset_last_data", SEL_LASTDATA, 32'h0);
         end
      end

      // Write x5 then read it back through the array
      applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
      checkOutput("x5_bypass_rd1", SEL_RD1, 32'hDEADBEEF);
      checkOutput("x5_bypass_rd2_x0", SEL_RD2, 32'h0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
      checkOutput("x5_array_rd1", SEL_RD1, 32'hDEADBEEF);
      checkOutput("x5_count", SEL_COUNT, 32'd1);
      checkOutput("x5_last_rd", SEL_LASTRD, 32'd5);
      checkOutput("x5_last_data", SEL_LASTDATA, 32'hDEADBEEF);

      // Same-cycle bypass on both ports, and its absence without wb_en
      applyStimulus(1'b0, 1'b0, 5'd7, 32'h12345678, 5'd7, 5'd7);
      checkOutput("x7_noen_rd1", SEL_RD1, 32'h0);
      checkOutput("x7_noen_rd2", SEL_RD2, 32'h0);
      applyStimulus(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
      checkOutput("x7_bypass_rd1", SEL_RD1, 32'h12345678);
      checkOutput("x7_bypass_rd2", SEL_RD2, 32'h12345678);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
      checkOutput("x7_array_rd1", SEL_RD1, 32'h12345678);
      checkOutput("x7_array_rd2_x5", SEL_RD2, 32'hDEADBEEF);
      checkOutput("x7_count", SEL_COUNT, 32'd2);
      checkOutput("x7_last_rd", SEL_LASTRD, 32'd7);

      // x0 write is ignored entirely
      applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5);
      checkOutput("x0_same_rd1", SEL_RD1, 32'h0);
      checkOutput("x0_same_rd2_x5", SEL_RD2, 32'hDEADBEEF);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      checkOutput("x0_next_rd1", SEL_RD1, 32'h0);
      checkOutput("x0_next_count", SEL_COUNT, 32'd2);
      checkOutput("x0_next_last_rd", SEL_LASTRD, 32'd7);
      checkOutput("x0_next_last_data", SEL_LASTDATA, 32'h12345678);

      // Reset arriving alongside a write cancels it and clears the file
      applyStimulus(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
      checkOutput("x3_array_rd1", SEL_RD1, 32'hA5A5A5A5);
      checkOutput("x3_count", SEL_COUNT, 32'd3);
      applyStimulus(1'b1, 1'b1, 5'd4, 32'h1, 5'd4, 5'd3);
      checkOutput("rst_nobypass_rd1_x4", SEL_RD1, 32'h0);
      checkOutput("rst_array_rd2_x3", SEL_RD2, 32'hA5A5A5A5);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd3);
      checkOutput("rst_after_rd1_x4", SEL_RD1, 32'h0);
      checkOutput("rst_after_rd2_x3", SEL_RD2, 32'h0);
      checkOutput("rst_after_count", SEL_COUNT, 32'h0);
      checkOutput("rst_after_last_rd", SEL_LASTRD, 32'h0);
      checkOutput("rst_after_last_data", SEL_LASTDATA, 32'h0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
      checkOutput("rst_after_rd1_x5", SEL_RD1, 32'h0);
      checkOutput("rst_after_rd2_x7", SEL_RD2, 32'h0);

      // Fifteen commits reach all-ones; the sixteenth wraps the counter
      for (int k = 1; k <= 15; k++) begin
         applyStimulus(1'b0, 1'b1, 5'(k), 32'h100 + 32'(k), 5'd0, 5'd0);
         checkOutput($sformatf("fill_count_%0d", k), SEL_COUNT, 32'(k - 1));
      end
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd15);
      checkOutput("fill_count_15", SEL_COUNT, 32'd15);
      checkOutput("fill_rd1_x9", SEL_RD1, 32'h109);
      checkOutput("fill_rd2_x15", SEL_RD2, 32'h10F);
      checkOutput("fill_last_rd", SEL_LASTRD, 32'd15);
      applyStimulus(1'b0, 1'b1, 5'd20, 32'hCAFEF00D, 5'd0, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd1);
      checkOutput("wrap_count", SEL_COUNT, 32'h0);
      checkOutput("wrap_rd1_x20", SEL_RD1, 32'hCAFEF00D);
      checkOutput("wrap_rd2_x1", SEL_RD2, 32'h101);
      checkOutput("wrap_last_rd", SEL_LASTRD, 32'd20);
      checkOutput("wrap_last_data", SEL_LASTDATA, 32'hCAFEF00D);

      @(negedge clock);
      #5;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0 pending", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
